// File: rtl/ram_sync_64x8.sv
// Single-port synchronous RAM with registered, write-through read data.
// Storage is a register array so the asynchronous reset can clear every word.
module ram_sync_64x8 #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: clearing the array in the reset branch forces flip-flop storage;
    // a RAM macro or inferred block RAM cannot be reset word-by-word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enable) begin
            // NOTE: non-blocking assignment keeps the read below seeing the
            // pre-edge contents, independent of process ordering.
            mem[address] <= data_in;
        end
    end

    // Write-through: a write edge presents the new data, a read edge the stored word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (enable) begin
            data_out <= data_in;
        end else begin
            data_out <= mem[address];
        end
    end

endmodule

// File: tb/tb_ram_sync_64x8.sv
// Directed self-checking bench for ram_sync_64x8; inputs change on the falling
// edge and data_out is sampled 1 time unit after each rising edge.
module tb_ram_sync_64x8;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [5:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_err = 0;

    ram_sync_64x8 #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] expected);
        n_cmp++;
        assert (data_out === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, data_out, expected);
        end
    endtask

    // Drive one operation on the falling edge, then sample after the rising edge.
    task automatic step(input logic en, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        enable  = en;
        address = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        address = '0;
        data_in = '0;
        #1;
        check("reset_immediate", 8'h00);
        @(posedge clk);
        #1;
        check("reset_clock_ignored", 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: reads after reset
        step(1'b0, 6'd0, 8'h11);  check("rst_read_0", 8'h00);
        step(1'b0, 6'd31, 8'h22); check("rst_read_31", 8'h00);
        step(1'b0, 6'd63, 8'h33); check("rst_read_63", 8'h00);

        // Test 2: write-through, held over two more edges
        step(1'b1, 6'd0, 8'd16);  check("wt_edge1", 8'd16);
        step(1'b1, 6'd0, 8'd16);  check("wt_edge2", 8'd16);
        step(1'b1, 6'd0, 8'd16);  check("wt_edge3", 8'd16);

        // Test 3: write then read back
        step(1'b1, 6'd5, 8'hA5);  check("wr_5_through", 8'hA5);
        step(1'b1, 6'd63, 8'h3C); check("wr_63_through", 8'h3C);
        step(1'b0, 6'd5, 8'h00);  check("rd_5", 8'hA5);
        step(1'b0, 6'd63, 8'h00); check("rd_63", 8'h3C);

        // data_out holds between edges despite input changes
        @(negedge clk);
        enable  = 1'b0;
        address = 6'd5;
        data_in = 8'h77;
        #1;
        check("stable_between_edges", 8'h3C);

        // Test 4: isolation around a written word
        step(1'b1, 6'd10, 8'hFF); check("wr_10_through", 8'hFF);
        step(1'b0, 6'd9, 8'h00);  check("iso_rd_9", 8'h00);
        step(1'b0, 6'd11, 8'h00); check("iso_rd_11", 8'h00);
        step(1'b0, 6'd10, 8'h00); check("iso_rd_10", 8'hFF);
        step(1'b0, 6'd0, 8'h00);  check("rd_0_kept", 8'd16);

        // Test 5: asynchronous reset between edges
        step(1'b0, 6'd5, 8'h00);  check("rd_5_before_reset", 8'hA5);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", 8'h00);
        enable  = 1'b1;
        address = 6'd20;
        data_in = 8'h55;
        @(posedge clk);
        #1;
        check("reset_blocks_write_edge", 8'h00);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        step(1'b0, 6'd5, 8'h00);  check("post_reset_rd_5", 8'h00);
        step(1'b0, 6'd63, 8'h00); check("post_reset_rd_63", 8'h00);
        step(1'b0, 6'd10, 8'h00); check("post_reset_rd_10", 8'h00);
        step(1'b0, 6'd20, 8'h00); check("lost_write_rd_20", 8'h00);

        // Test 6: overwrite, last write wins
        step(1'b1, 6'd7, 8'd1);   check("ow_first", 8'd1);
        step(1'b1, 6'd7, 8'd2);   check("ow_second", 8'd2);
        step(1'b0, 6'd0, 8'h00);  check("rd_0_after_reset", 8'h00);
        step(1'b0, 6'd7, 8'h99);  check("ow_rd_7", 8'd2);
        step(1'b0, 6'd7, 8'h00);  check("read_does_not_write", 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
